// File: rtl/uart_baud_pkg.sv
// Shared types and widths for the UART receive baud-rate generator.
package uart_baud_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;
  localparam int FRAC_WIDTH        = 4;
  localparam int ACQ_WIDTH         = 4;

  // Active configuration snapshot at the default divisor width.
  typedef struct packed {
    logic [DIV_WIDTH_DEFAULT-1:0] div;
    logic [ACQ_WIDTH-1:0]         acq;
    logic [FRAC_WIDTH-1:0]        frac;
  } baud_cfg_t;

  // A bit needs at least one acquisition, so zero is promoted to one.
  function automatic logic [ACQ_WIDTH-1:0] acq_clamp(input logic [ACQ_WIDTH-1:0] acq_in);
    return (acq_in == {ACQ_WIDTH{1'b0}}) ? {{(ACQ_WIDTH-1){1'b0}}, 1'b1} : acq_in;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional accumulator: adds the fraction on each acquisition tick and
// keeps the carry pending so the next acquisition period is one clk longer.
module baud_frac_acc
  import uart_baud_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  tick,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic                  carry
);

  logic [FRAC_WIDTH-1:0] acc_r;
  logic                  carry_r;
  logic [FRAC_WIDTH:0]   sum_s;

  assign sum_s = {1'b0, acc_r} + {1'b0, frac};
  assign carry = carry_r;

  // Accumulate on ticks; the carry stays valid until the next tick replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r   <= {FRAC_WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (clr) begin
      acc_r   <= {FRAC_WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (tick) begin
      acc_r   <= sum_s[FRAC_WIDTH-1:0];
      carry_r <= sum_s[FRAC_WIDTH];
    end
  end

endmodule

// File: rtl/baudrate_gen.sv
// Acquisition/bit strobe generator for the receive path.
// Optional fractional divider built when BAUD_FRAC_DIV_EN is defined.
module baudrate_gen
  import uart_baud_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_Enable_i,
  input  logic [DIV_WIDTH-1:0]  Divisor_i,
  input  logic [FRAC_WIDTH-1:0] FracDiv_i,
  input  logic [ACQ_WIDTH-1:0]  AcqNumPerBit_i,
  input  logic                  p_Resync_i,
  output logic                  AcqSig_o,
  output logic                  BaudSig_o,
  output logic [ACQ_WIDTH-1:0]  BitPhase_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACQ_WIDTH-1:0] ACQ_ONE = {{(ACQ_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [DIV_WIDTH-1:0]  div;
    logic [ACQ_WIDTH-1:0]  acq;
    logic [FRAC_WIDTH-1:0] frac;
  } cfg_t;

  cfg_t                  cfg_r;
  logic                  run_r;
  logic [DIV_WIDTH-1:0]  div_cnt_r;
  logic                  ext_r;
  logic [ACQ_WIDTH-1:0]  acq_cnt_r;
  logic                  acq_r;
  logic                  baud_r;
  logic [ACQ_WIDTH-1:0]  phase_r;

  logic                  active_s;
  logic                  hold_s;
  logic                  load_s;
  logic [DIV_WIDTH-1:0]  div_in_s;
  logic [FRAC_WIDTH-1:0] frac_in_s;
  logic                  div_hit_s;
  logic                  carry_s;
  logic                  tick_s;
  logic                  stretch_s;
  logic                  acq_last_s;

  // The first enabled edge only aligns the phase, so counting starts one edge later.
  assign active_s   = run_r & p_Enable_i;
  assign hold_s     = ~active_s | p_Resync_i;
  assign load_s     = hold_s | baud_r;
  assign div_in_s   = (Divisor_i == {DIV_WIDTH{1'b0}}) ? DIV_ONE : Divisor_i;
  assign div_hit_s  = (div_cnt_r == cfg_r.div);
  assign tick_s     = ~hold_s & div_hit_s & (~carry_s | ext_r);
  assign stretch_s  = ~hold_s & div_hit_s & carry_s & ~ext_r;
  assign acq_last_s = (acq_cnt_r == (cfg_r.acq - ACQ_ONE));

`ifdef BAUD_FRAC_DIV_EN
  assign frac_in_s = FracDiv_i;

  baud_frac_acc u_frac_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (hold_s),
    .tick  (tick_s),
    .frac  (cfg_r.frac),
    .carry (carry_s)
  );
`else
  logic frac_unused_s;
  assign frac_in_s     = {FRAC_WIDTH{1'b0}};
  assign carry_s       = 1'b0;
  assign frac_unused_s = ^{FracDiv_i, cfg_r.frac};
`endif

  // Shadow configuration: refreshed only at bit boundaries while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_r <= '0;
      run_r <= 1'b0;
    end else begin
      run_r <= p_Enable_i;
      if (load_s) begin
        cfg_r.div  <= div_in_s;
        cfg_r.acq  <= acq_clamp(AcqNumPerBit_i);
        cfg_r.frac <= frac_in_s;
      end
    end
  end

  // Divider and acquisition counters; wrap by explicit compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= {DIV_WIDTH{1'b0}};
      ext_r     <= 1'b0;
      acq_cnt_r <= {ACQ_WIDTH{1'b0}};
    end else if (hold_s) begin
      div_cnt_r <= {DIV_WIDTH{1'b0}};
      ext_r     <= 1'b0;
      acq_cnt_r <= {ACQ_WIDTH{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_WIDTH{1'b0}};
      ext_r     <= 1'b0;
      acq_cnt_r <= acq_last_s ? {ACQ_WIDTH{1'b0}} : (acq_cnt_r + ACQ_ONE);
    end else if (stretch_s) begin
      ext_r     <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Registered strobes; BitPhase reports the index of the latest acquisition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acq_r   <= 1'b0;
      baud_r  <= 1'b0;
      phase_r <= {ACQ_WIDTH{1'b0}};
    end else if (hold_s) begin
      acq_r   <= 1'b0;
      baud_r  <= 1'b0;
      phase_r <= {ACQ_WIDTH{1'b0}};
    end else begin
      acq_r  <= tick_s;
      baud_r <= tick_s & acq_last_s;
      if (tick_s) begin
        phase_r <= acq_cnt_r;
      end
    end
  end

  assign AcqSig_o   = acq_r;
  assign BaudSig_o  = baud_r;
  assign BitPhase_o = phase_r;

endmodule
